// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared bf16 widths, classifier flag indices and special-case codes
package bf16_pkg;

    localparam int NUM_WIDTH  = 16;
    localparam int EXP_WIDTH  = 8;
    localparam int SIG_WIDTH  = 7;
    localparam int FLAG_WIDTH = 4;
    localparam int EXT_WIDTH  = EXP_WIDTH + 2;

    localparam int NAN  = 3;
    localparam int ZERO = 2;
    localparam int INF  = 1;
    localparam int NORM = 0;

    localparam int                   BIAS = 127;
    localparam logic [NUM_WIDTH-1:0] QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_QNAN = 2'd3
    } cls_e;

endpackage

// File: rtl/bf16_round_norm.sv
// rtl/bf16_round_norm.sv - normalize a 16-bit significand product and round to nearest even
module bf16_round_norm
    import bf16_pkg::*;
(
    input  logic        [2*SIG_WIDTH+1:0] i_prod,
    input  logic signed [EXT_WIDTH-1:0]   i_exp,
    output logic        [SIG_WIDTH-1:0]   o_frac,
    output logic signed [EXT_WIDTH-1:0]   o_exp
);

    logic        [SIG_WIDTH-1:0] w_frac;
    logic                        w_guard;
    logic                        w_sticky;
    logic                        w_up;
    logic        [SIG_WIDTH:0]   w_sum;
    logic signed [EXT_WIDTH-1:0] w_exp;

    always_comb begin
        if (i_prod[15]) begin
            w_frac   = i_prod[14:8];
            w_guard  = i_prod[7];
            w_sticky = |i_prod[6:0];
            w_exp    = i_exp + 10'sd1;
        end else begin
            w_frac   = i_prod[13:7];
            w_guard  = i_prod[6];
            w_sticky = |i_prod[5:0];
            w_exp    = i_exp;
        end
        w_up  = w_guard & (w_sticky | w_frac[0]);
        // A carry out of an all-ones fraction leaves zeros below it and bumps the exponent
        w_sum = {1'b0, w_frac} + {{SIG_WIDTH{1'b0}}, w_up};
        o_frac = w_sum[SIG_WIDTH-1:0];
        o_exp  = w_sum[SIG_WIDTH] ? w_exp + 10'sd1 : w_exp;
    end

endmodule

// File: rtl/bf16_mul_pipe.sv
// rtl/bf16_mul_pipe.sv - three-stage bf16 multiplier on classifier fields, RNE and flush-to-zero
module bf16_mul_pipe
    import bf16_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [FLAG_WIDTH-1:0] i_flag_a,
    input  logic [FLAG_WIDTH-1:0] i_flag_b,
    input  logic [SIG_WIDTH-1:0]  i_sig_a,
    input  logic [SIG_WIDTH-1:0]  i_sig_b,
    input  logic [EXP_WIDTH-1:0]  i_exp_a,
    input  logic [EXP_WIDTH-1:0]  i_exp_b,
    input  logic                  i_sign_a,
    input  logic                  i_sign_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NUM_WIDTH-1:0]  o_data
);

    logic                        w_en;
    logic [SIG_WIDTH-1:0]        w_sig_a, w_sig_b;
    logic [EXP_WIDTH-1:0]        w_exp_a, w_exp_b;
    logic signed [EXT_WIDTH-1:0] w_exp_sum;
    logic [NUM_WIDTH-1:0]        w_prod;
    cls_e                        w_cls;

    logic                        r_v1, r_v2, r_v3;
    logic                        r_sign1, r_sign2;
    logic signed [EXT_WIDTH-1:0] r_exp1, r_exp2;
    logic [NUM_WIDTH-1:0]        r_prod1;
    logic [SIG_WIDTH-1:0]        r_frac2;
    cls_e                        r_cls1, r_cls2;
    logic [NUM_WIDTH-1:0]        r_data3;

    logic [SIG_WIDTH-1:0]        w_frac_rn;
    logic signed [EXT_WIDTH-1:0] w_exp_rn;
    logic signed [EXT_WIDTH-1:0] w_bexp;
    logic [NUM_WIDTH-1:0]        w_pack;

    assign w_en    = ~r_v3 | i_ready;
    assign o_ready = w_en;
    assign o_valid = r_v3;
    assign o_data  = r_data3;

    assign w_sig_a   = i_flag_a[NORM] ? i_sig_a : '0;
    assign w_sig_b   = i_flag_b[NORM] ? i_sig_b : '0;
    assign w_exp_a   = i_flag_a[NORM] ? i_exp_a : '0;
    assign w_exp_b   = i_flag_b[NORM] ? i_exp_b : '0;
    assign w_exp_sum = {{2{w_exp_a[EXP_WIDTH-1]}}, w_exp_a} + {{2{w_exp_b[EXP_WIDTH-1]}}, w_exp_b};
    assign w_prod    = {8'd0, 1'b1, w_sig_a} * {8'd0, 1'b1, w_sig_b};

    always_comb begin
        w_cls = CLS_NORM;
        if (i_flag_a[NAN] | i_flag_b[NAN])
            w_cls = CLS_QNAN;
        else if ((i_flag_a[INF] & i_flag_b[ZERO]) | (i_flag_a[ZERO] & i_flag_b[INF]))
            w_cls = CLS_QNAN;
        else if (i_flag_a[INF] | i_flag_b[INF])
            w_cls = CLS_INF;
        else if (i_flag_a[ZERO] | i_flag_b[ZERO])
            w_cls = CLS_ZERO;
    end

    bf16_round_norm u_round_norm (
        .i_prod (r_prod1),
        .i_exp  (r_exp1),
        .o_frac (w_frac_rn),
        .o_exp  (w_exp_rn)
    );

    // Class is resolved before range so a zero or inf operand never reads the masked exponent
    assign w_bexp = r_exp2 + 10'sd127;
    always_comb begin
        w_pack = {r_sign2, w_bexp[EXP_WIDTH-1:0], r_frac2};
        if (r_cls2 == CLS_QNAN)
            w_pack = QNAN;
        else if (r_cls2 == CLS_INF || r_exp2 > 10'sd127)
            w_pack = {r_sign2, 8'hFF, 7'h00};
        else if (r_cls2 == CLS_ZERO || r_exp2 < -10'sd126)
            w_pack = {r_sign2, 15'h0000};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_exp1  <= '0;
            r_exp2  <= '0;
            r_prod1 <= '0;
            r_frac2 <= '0;
            r_cls1  <= CLS_ZERO;
            r_cls2  <= CLS_ZERO;
            r_data3 <= '0;
        end else if (w_en) begin
            r_v1    <= i_valid;
            r_sign1 <= i_sign_a ^ i_sign_b;
            r_exp1  <= w_exp_sum;
            r_prod1 <= w_prod;
            r_cls1  <= w_cls;
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_exp2  <= w_exp_rn;
            r_frac2 <= w_frac_rn;
            r_cls2  <= r_cls1;
            r_v3    <= r_v2;
            r_data3 <= w_pack;
        end
    end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// tb/tb_bf16_mul_pipe.sv - directed-vector bench for bf16_mul_pipe
module tb_bf16_mul_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_flag_a = '0, i_flag_b = '0;
    logic [6:0]  i_sig_a = '0, i_sig_b = '0;
    logic [7:0]  i_exp_a = '0, i_exp_b = '0;
    logic        i_sign_a = 1'b0, i_sign_b = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_data;

    int n_vec  = 0;
    int n_miss = 0;

    bf16_mul_pipe dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_flag_a (i_flag_a),
        .i_flag_b (i_flag_b),
        .i_sig_a  (i_sig_a),
        .i_sig_b  (i_sig_b),
        .i_exp_a  (i_exp_a),
        .i_exp_b  (i_exp_b),
        .i_sign_a (i_sign_a),
        .i_sign_b (i_sign_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data)
    );

    always #5 i_clk = ~i_clk;

    // Classifier stand-in: flags {nan, zero, inf, norm}, subnormals reported as zero
    function automatic logic [3:0] cls_of(input logic [15:0] x);
        if (x[14:7] == 8'hFF)
            return (x[6:0] != 7'd0) ? 4'b1000 : 4'b0010;
        else if (x[14:7] == 8'h00)
            return 4'b0100;
        return 4'b0001;
    endfunction

    // {a, b, expected product}
    function automatic logic [47:0] vec(input int i);
        case (i)
            0: return {16'h3FC0, 16'h4000, 16'h4040};
            1: return {16'h3FC0, 16'h3F81, 16'h3FC2};
            2: return {16'h3FFF, 16'h3FFF, 16'h407E};
            3: return {16'h7F00, 16'h4000, 16'h7F80};
            4: return {16'h0080, 16'h3F00, 16'h0000};
            5: return {16'h8080, 16'h3F00, 16'h8000};
            6: return {16'h7F80, 16'h0000, 16'h7FC0};
            7: return {16'h7FC1, 16'h3F80, 16'h7FC0};
            8: return {16'hFF80, 16'h4000, 16'hFF80};
            9: return {16'h0000, 16'hC040, 16'h8000};
            default: return 48'h0;
        endcase
    endfunction

    task automatic drive_pair(input logic [15:0] a, input logic [15:0] b);
        i_valid  = 1'b1;
        i_flag_a = cls_of(a);
        i_flag_b = cls_of(b);
        i_sig_a  = a[6:0];
        i_sig_b  = b[6:0];
        i_exp_a  = a[14:7] - 8'd127;
        i_exp_b  = b[14:7] - 8'd127;
        i_sign_a = a[15];
        i_sign_b = b[15];
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        n_vec++;
        if (o_valid !== 1'b0) begin n_miss++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_vec++;
        if (o_data !== 16'h0000) begin n_miss++; $display("FAIL reset_o_data: got %h want 0000", o_data); end
        i_rst = 1'b0;
        #1;
        n_vec++;
        if (o_ready !== 1'b1) begin n_miss++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_latency();
        logic [47:0] v;
        v = vec(0);
        i_ready = 1'b1;
        @(negedge i_clk);
        drive_pair(v[47:32], v[31:16]);
        @(posedge i_clk);
        @(negedge i_clk);
        idle();
        n_vec++;
        if (o_valid !== 1'b0) begin n_miss++; $display("FAIL latency_edge1: o_valid got %b want 0", o_valid); end
        @(negedge i_clk);
        n_vec++;
        if (o_valid !== 1'b0) begin n_miss++; $display("FAIL latency_edge2: o_valid got %b want 0", o_valid); end
        @(negedge i_clk);
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== v[15:0]) begin
            n_miss++;
            $display("FAIL latency_edge3: got v=%b d=%h want v=1 d=%h", o_valid, o_data, v[15:0]);
        end
        @(negedge i_clk);
        n_vec++;
        if (o_valid !== 1'b0) begin n_miss++; $display("FAIL latency_drain: o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_vectors();
        logic [47:0] v;
        bit          seen;
        for (int i = 0; i < 10; i++) begin
            v = vec(i);
            @(negedge i_clk);
            drive_pair(v[47:32], v[31:16]);
            @(posedge i_clk);
            @(negedge i_clk);
            idle();
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (o_valid === 1'b1) seen = 1'b1;
                else @(negedge i_clk);
            end
            n_vec++;
            if (!seen) begin
                n_miss++;
                $display("FAIL vec%0d_timeout: no o_valid within budget, want %h", i, v[15:0]);
            end else if (o_data !== v[15:0]) begin
                n_miss++;
                $display("FAIL vec%0d %h*%h: got %h want %h", i, v[47:32], v[31:16], o_data, v[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] v;
        int          in_idx, out_idx, stall_left;
        bit          stall_done;
        in_idx = 0; out_idx = 0; stall_left = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            @(negedge i_clk);
            if (!stall_done && o_valid && stall_left == 0) begin
                stall_left = 2;
                stall_done = 1'b1;
            end
            i_ready = (stall_left == 0);
            if (in_idx < 6) begin
                v = vec(in_idx);
                drive_pair(v[47:32], v[31:16]);
            end else begin
                idle();
            end
            #1;
            if (stall_left > 0) begin
                v = vec(out_idx);
                n_vec++;
                if (o_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_stall_o_ready: got %b want 0", o_ready); end
                n_vec++;
                if (o_valid !== 1'b1 || o_data !== v[15:0]) begin
                    n_miss++;
                    $display("FAIL b2b_stall_hold: got v=%b d=%h want v=1 d=%h", o_valid, o_data, v[15:0]);
                end
                stall_left--;
            end
            if (i_valid && o_ready) in_idx++;
            if (o_valid && i_ready) begin
                v = vec(out_idx);
                n_vec++;
                if (o_data !== v[15:0]) begin
                    n_miss++;
                    $display("FAIL b2b_out%0d: got %h want %h", out_idx, o_data, v[15:0]);
                end
                out_idx++;
            end
        end
        n_vec++;
        if (out_idx != 6 || !stall_done) begin
            n_miss++;
            $display("FAIL b2b_count: got %0d results stall=%0d want 6 stall=1", out_idx, stall_done);
        end
        @(negedge i_clk);
        idle();
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            n_vec++;
            if (o_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_no_dup: o_valid got %b want 0", o_valid); end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [47:0] v;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v = vec(k + 3);
            @(negedge i_clk);
            drive_pair(v[47:32], v[31:16]);
        end
        @(negedge i_clk);
        idle();
        n_vec++;
        if (o_valid !== 1'b1) begin n_miss++; $display("FAIL rst_pre_valid: got %b want 1", o_valid); end
        i_rst = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0) begin n_miss++; $display("FAIL rst_async_valid: got %b want 0", o_valid); end
        n_vec++;
        if (o_data !== 16'h0000) begin n_miss++; $display("FAIL rst_async_data: got %h want 0000", o_data); end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        n_vec++;
        if (o_ready !== 1'b1) begin n_miss++; $display("FAIL rst_release_ready: got %b want 1", o_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            n_vec++;
            if (o_valid !== 1'b0) begin n_miss++; $display("FAIL rst_no_stale: o_valid got %b want 0", o_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
